// File: rtl/ddr_tx_sequencer.sv
// rtl/ddr_tx_sequencer.sv - word-to-(dp,dn) beat sequencer for a dual-edge output flop; optional parity beat via DDR_TX_SEQ_PARITY_EN
module ddr_tx_sequencer #(
    parameter int   DATA_WIDTH = 1,
    parameter int   WORD_WIDTH = 16,
    parameter int   GAP_CYCLES = 2,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WORD_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] dp,
    output logic [DATA_WIDTH-1:0] dn,
    output logic                  tx_en,
    output logic                  frame_active,
    output logic                  busy
);

    localparam int BEATS      = WORD_WIDTH / (2 * DATA_WIDTH);
    localparam int CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int GAP_W      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int SHIFT_STEP = 2 * DATA_WIDTH;

    localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [GAP_W-1:0]      LAST_GAP  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [DATA_WIDTH-1:0] IDLE_LANE = {DATA_WIDTH{IDLE_LEVEL}};

    // A word must split into a whole number of (dp,dn) beats.
    if ((WORD_WIDTH % (2 * DATA_WIDTH)) != 0) begin : g_width_check
        $error("ddr_tx_sequencer: WORD_WIDTH must be a multiple of 2*DATA_WIDTH");
    end

`ifdef DDR_TX_SEQ_PARITY_EN
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_GAP    = 2'd2,
        S_PARITY = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;
`endif

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [GAP_W-1:0]        gap_q, gap_d;
    logic [WORD_WIDTH-1:0]   shift_q, shift_d;
    logic                    last_q, last_d;
    // Frame still open while stalled in IDLE between words of one frame.
    logic                    open_q, open_d;

    logic [DATA_WIDTH-1:0]   dp_q, dp_d;
    logic [DATA_WIDTH-1:0]   dn_q, dn_d;
    logic                    tx_en_q, tx_en_d;
    logic                    frame_active_q, frame_active_d;

`ifdef DDR_TX_SEQ_PARITY_EN
    logic [DATA_WIDTH-1:0]   acc_dp_q, acc_dp_d;
    logic [DATA_WIDTH-1:0]   acc_dn_q, acc_dn_d;
`endif

    logic [DATA_WIDTH-1:0]   beat_dp;
    logic [DATA_WIDTH-1:0]   beat_dn;
    logic                    final_beat;

    // Current beat is always the top 2*D bits of the shift register, MSB-first.
    assign beat_dp    = shift_q[WORD_WIDTH-1 -: DATA_WIDTH];
    assign beat_dn    = shift_q[WORD_WIDTH-1-DATA_WIDTH -: DATA_WIDTH];
    assign final_beat = (state_q == S_SHIFT) && (cnt_q == LAST_BEAT);

    // Ready depends only on registered state, never on s_valid.
    assign s_ready = (state_q == S_IDLE) || (final_beat && !last_q);

    assign busy         = (state_q != S_IDLE);
    assign dp           = dp_q;
    assign dn           = dn_q;
    assign tx_en        = tx_en_q;
    assign frame_active = frame_active_q;

    // State register and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            gap_q   <= '0;
            shift_q <= '0;
            last_q  <= 1'b0;
            open_q  <= 1'b0;
`ifdef DDR_TX_SEQ_PARITY_EN
            acc_dp_q <= '0;
            acc_dn_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            shift_q <= shift_d;
            last_q  <= last_d;
            open_q  <= open_d;
`ifdef DDR_TX_SEQ_PARITY_EN
            acc_dp_q <= acc_dp_d;
            acc_dn_q <= acc_dn_d;
`endif
        end
    end

    // Next-state: accept words, step beats, chain back-to-back words, time the gap.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        shift_d = shift_q;
        last_d  = last_q;
        open_d  = open_q;
`ifdef DDR_TX_SEQ_PARITY_EN
        acc_dp_d = acc_dp_q;
        acc_dn_d = acc_dn_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (s_valid) begin
                    state_d = S_SHIFT;
                    shift_d = s_data;
                    last_d  = s_last;
                    cnt_d   = '0;
                    open_d  = 1'b0;
`ifdef DDR_TX_SEQ_PARITY_EN
                    // A fresh frame starts the parity over; a resumed one keeps it.
                    if (!open_q) begin
                        acc_dp_d = '0;
                        acc_dn_d = '0;
                    end
`endif
                end
            end
            S_SHIFT: begin
`ifdef DDR_TX_SEQ_PARITY_EN
                acc_dp_d = acc_dp_q ^ beat_dp;
                acc_dn_d = acc_dn_q ^ beat_dn;
`endif
                if (cnt_q != LAST_BEAT) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    shift_d = shift_q << SHIFT_STEP;
                end else if (last_q) begin
                    gap_d = '0;
`ifdef DDR_TX_SEQ_PARITY_EN
                    state_d = S_PARITY;
`else
                    if (GAP_CYCLES > 0) begin
                        state_d = S_GAP;
                    end else begin
                        state_d = S_IDLE;
                    end
`endif
                end else if (s_valid) begin
                    // Next word of the same frame follows with no bubble.
                    shift_d = s_data;
                    last_d  = s_last;
                    cnt_d   = '0;
                end else begin
                    state_d = S_IDLE;
                    open_d  = 1'b1;
                end
            end
            S_GAP: begin
                if (gap_q == LAST_GAP) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
`ifdef DDR_TX_SEQ_PARITY_EN
            S_PARITY: begin
                gap_d = '0;
                if (GAP_CYCLES > 0) begin
                    state_d = S_GAP;
                end else begin
                    state_d = S_IDLE;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output next-values: registered one clock behind the state that produces them.
    always_comb begin
        dp_d           = IDLE_LANE;
        dn_d           = IDLE_LANE;
        tx_en_d        = 1'b0;
        frame_active_d = 1'b0;
        case (state_q)
            S_SHIFT: begin
                dp_d           = beat_dp;
                dn_d           = beat_dn;
                tx_en_d        = 1'b1;
                frame_active_d = 1'b1;
            end
`ifdef DDR_TX_SEQ_PARITY_EN
            S_PARITY: begin
                dp_d           = acc_dp_q;
                dn_d           = acc_dn_q;
                tx_en_d        = 1'b1;
                frame_active_d = 1'b1;
            end
`endif
            S_IDLE: begin
                frame_active_d = open_q;
            end
            default: begin
                frame_active_d = 1'b0;
            end
        endcase
    end

    // Output registers; reset forces the idle level immediately.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dp_q           <= IDLE_LANE;
            dn_q           <= IDLE_LANE;
            tx_en_q        <= 1'b0;
            frame_active_q <= 1'b0;
        end else begin
            dp_q           <= dp_d;
            dn_q           <= dn_d;
            tx_en_q        <= tx_en_d;
            frame_active_q <= frame_active_d;
        end
    end

endmodule

// File: tb/tb_ddr_tx_sequencer.sv
// tb/tb_ddr_tx_sequencer.sv - directed table-driven bench for ddr_tx_sequencer
module tb_ddr_tx_sequencer;

    localparam int G1 = 2;
`ifdef DDR_TX_SEQ_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, s_valid, s_last, s_ready, tx_en, frame_active, busy;
    logic [7:0] s_data;
    logic [0:0] dp, dn;

    logic       rst_b, sb_valid, sb_last, sb_ready, tx_en_b, fa_b, busy_b;
    logic [7:0] sb_data;
    logic [0:0] dp_b, dn_b;

    ddr_tx_sequencer #(.DATA_WIDTH(1), .WORD_WIDTH(8), .GAP_CYCLES(G1), .IDLE_LEVEL(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready), .dp(dp), .dn(dn), .tx_en(tx_en), .frame_active(frame_active), .busy(busy)
    );

    ddr_tx_sequencer #(.DATA_WIDTH(1), .WORD_WIDTH(8), .GAP_CYCLES(0), .IDLE_LEVEL(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_b), .s_data(sb_data), .s_valid(sb_valid), .s_last(sb_last),
        .s_ready(sb_ready), .dp(dp_b), .dn(dn_b), .tx_en(tx_en_b), .frame_active(fa_b), .busy(busy_b)
    );

    typedef struct {
        logic [7:0] data;
        logic [3:0] exp_dp;   // bit 3 = beat 0
        logic [3:0] exp_dn;
        logic [1:0] exp_par;  // {dp, dn} of the parity beat
    } vec_t;

    vec_t vecs [5];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic edp, input logic edn, input logic etx, input logic efa);
        chk(name, {28'd0, dp, dn, tx_en, frame_active}, {28'd0, edp, edn, etx, efa});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // After the last payload beat: GAP clocks with s_ready low, then IDLE.
    task automatic check_gap(input string tag);
        for (int g = 0; g < G1; g++) begin
            chk($sformatf("%s gap%0d ready", tag, g), s_ready, 1'b0);
            chk($sformatf("%s gap%0d busy", tag, g), busy, 1'b1);
            tick();
            chk_out($sformatf("%s gap%0d out", tag, g), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        chk($sformatf("%s ready_after_gap", tag), s_ready, 1'b1);
        chk($sformatf("%s busy_after_gap", tag), busy, 1'b0);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        chk($sformatf("%s ready_idle", tag), s_ready, 1'b1);
        s_data = v.data; s_last = 1'b1; s_valid = 1'b1;
        tick();
        s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
        chk_out($sformatf("%s accept_cycle", tag), 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s ready_beat%0d", tag, k), s_ready, 1'b0);
            tick();
            chk_out($sformatf("%s beat%0d", tag, k), v.exp_dp[3-k], v.exp_dn[3-k], 1'b1, 1'b1);
        end
`ifdef DDR_TX_SEQ_PARITY_EN
        chk($sformatf("%s ready_parity", tag), s_ready, 1'b0);
        tick();
        chk_out($sformatf("%s parity", tag), v.exp_par[1], v.exp_par[0], 1'b1, 1'b1);
`endif
        check_gap(tag);
    endtask

    initial begin
        vecs[0] = '{8'hB4, 4'b1100, 4'b0110, 2'b00};
        vecs[1] = '{8'hB0, 4'b1100, 4'b0100, 2'b01};
        vecs[2] = '{8'h5A, 4'b0011, 4'b1100, 2'b00};
        vecs[3] = '{8'hC0, 4'b1000, 4'b1000, 2'b11};
        vecs[4] = '{8'h80, 4'b1000, 4'b0000, 2'b10};

        rst_n = 1'b0; s_data = 8'h00; s_valid = 1'b0; s_last = 1'b0;
        rst_b = 1'b0; sb_data = 8'h00; sb_valid = 1'b0; sb_last = 1'b0;
        tick();
        tick();
        chk_out("reset outputs", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset busy", busy, 1'b0);
        chk("reset b idle level", {30'd0, dp_b, dn_b}, 32'h3);
        chk("reset b busy", busy_b, 1'b0);
        rst_n = 1'b1;
        chk("reset ready", s_ready, 1'b1);

        // Single-word frames from the table.
        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Back-to-back 0xFF, 0x00 with s_valid held high.
        s_data = 8'hFF; s_last = 1'b0; s_valid = 1'b1;
        tick();
        s_data = 8'h00; s_last = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 3) begin
                s_valid = 1'b0; s_last = 1'b0;
            end
            chk_out($sformatf("b2b beat%0d", i), (i < 4), (i < 4), 1'b1, 1'b1);
            chk($sformatf("b2b ready%0d", i), s_ready, (i == 2));
        end
`ifdef DDR_TX_SEQ_PARITY_EN
        tick();
        chk_out("b2b parity", 1'b0, 1'b0, 1'b1, 1'b1);
`endif
        tick();
        chk_out("b2b frame_end", 1'b0, 1'b0, 1'b0, 1'b0);
        for (int g = 1; g < G1; g++) tick();
        chk("b2b ready_after", s_ready, 1'b1);

        // 0xA5, three-clock stall, then 0x5A (last).
        begin
            logic [3:0] a5_dp, a5_dn, x5a_dp, x5a_dn;
            a5_dp = 4'b1100; a5_dn = 4'b0011; x5a_dp = 4'b0011; x5a_dn = 4'b1100;
            s_data = 8'hA5; s_last = 1'b0; s_valid = 1'b1;
            tick();
            s_valid = 1'b0;
            for (int k = 0; k < 4; k++) begin
                tick();
                chk_out($sformatf("stall a5 beat%0d", k), a5_dp[3-k], a5_dn[3-k], 1'b1, 1'b1);
            end
            chk("stall ready_idle", s_ready, 1'b1);
            for (int j = 0; j < 3; j++) begin
                if (j == 2) begin
                    s_data = 8'h5A; s_last = 1'b1; s_valid = 1'b1;
                end
                tick();
                chk_out($sformatf("stall hole%0d", j), 1'b0, 1'b0, 1'b0, 1'b1);
            end
            s_valid = 1'b0; s_last = 1'b0;
            for (int k = 0; k < 4; k++) begin
                tick();
                chk_out($sformatf("stall 5a beat%0d", k), x5a_dp[3-k], x5a_dn[3-k], 1'b1, 1'b1);
            end
`ifdef DDR_TX_SEQ_PARITY_EN
            tick();
            chk_out("stall parity", 1'b0, 1'b0, 1'b1, 1'b1);
`endif
            tick();
            chk_out("stall frame_end", 1'b0, 1'b0, 1'b0, 1'b0);
            for (int g = 1; g < G1; g++) tick();
            chk("stall ready_after", s_ready, 1'b1);
        end

        // Reset during beat 2 of 0xB4, then a clean retransmit.
        s_data = 8'hB4; s_last = 1'b1; s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        tick(); chk_out("rst beat0", 1'b1, 1'b0, 1'b1, 1'b1);
        tick(); chk_out("rst beat1", 1'b1, 1'b1, 1'b1, 1'b1);
        tick(); chk_out("rst beat2", 1'b0, 1'b1, 1'b1, 1'b1);
        rst_n = 1'b0;
        tick();
        chk_out("rst outputs idle", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst busy", busy, 1'b0);
        rst_n = 1'b1;
        chk("rst ready_after", s_ready, 1'b1);
        tick();
        chk_out("rst stays idle", 1'b0, 1'b0, 1'b0, 1'b0);
        run_vec(vecs[0], "post_rst");

        // GAP_CYCLES=0 instance, idle level 1: two single-word frames back-to-back.
        rst_b = 1'b1;
        tick();
        chk("g0 ready_idle", sb_ready, 1'b1);
        sb_data = 8'hB4; sb_last = 1'b1; sb_valid = 1'b1;
        for (int n = 0; n <= 8 + P; n++) begin
            logic etx;
            tick();
            etx = ((n >= 1) && (n <= 4 + P)) || ((n >= 6 + P) && (n <= 8 + P));
            chk($sformatf("g0 tx%0d", n), tx_en_b, etx);
            chk($sformatf("g0 ready%0d", n), sb_ready, (n == 4 + P));
            if (!etx) begin
                chk($sformatf("g0 idle_level%0d", n), {30'd0, dp_b, dn_b}, 32'h3);
            end
        end
        sb_valid = 1'b0; sb_last = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ddr_tx_sequencer.md
Name: ddr_tx_sequencer

Overview:
Sequences parallel words from an upstream valid/ready stream into per-clock (dp, dn) lane pairs for a downstream dual-edge output register.
- dp is the rising-edge half of each beat; dn is the falling-edge half.
- Inserts inter-frame gaps and drives an idle level between frames.
- Sits between the sample/packet formatter and the dual-edge output flop in the host-link transmit path.

Parameters:
DATA_WIDTH, 1, lane width; width of dp and dn.
WORD_WIDTH, 16, input word width; must be a multiple of 2*DATA_WIDTH (compile-time check; elaboration error otherwise).
GAP_CYCLES, 2, idle clocks forced after each frame's last beat; 0 allowed.
IDLE_LEVEL, 0, 1-bit value replicated on dp and dn when not transmitting.

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous, active-low reset
s_data  in  WORD_WIDTH  input word
s_valid  in  1  s_data valid
s_last  in  1  word is the last of its frame
s_ready  out  1  sequencer accepts s_data this cycle
dp  out  DATA_WIDTH  rising-edge lane data to dual-edge flop
dn  out  DATA_WIDTH  falling-edge lane data to dual-edge flop
tx_en  out  1  dp/dn carry payload (or parity) this cycle
frame_active  out  1  high from first beat of a frame through its final beat
busy  out  1  state != IDLE

Behaviour:
- BEATS = WORD_WIDTH/(2*DATA_WIDTH). Beat counter width is clog2(BEATS), minimum 1.
- States:
  - IDLE: s_ready=1. On accept (s_valid && s_ready), load shift register, latch s_last, go to SHIFT.
  - SHIFT: emit one beat per clk. s_ready=1 only on the final beat of the current word, and only if that word is not last.
  - GAP: s_ready=0. Stay exactly GAP_CYCLES clocks. If GAP_CYCLES=0, go straight to IDLE.
- Beat order is MSB-first. Beat k: dp = s_data[WORD_WIDTH-1-2kD -: D], dn = next D bits below (D=DATA_WIDTH).
- All outputs are registered. A word accepted on edge t puts its beat 0 on dp/dn/tx_en after edge t+1 and holds it for one clk.
- Back-to-back words: if a word is accepted on the final beat of a non-last word, its beat 0 follows immediately. No bubble; frame_active stays high.
- Final beat of a last word:
  - Next state is GAP (GAP_CYCLES>0) or IDLE.
  - frame_active and tx_en drop after the next edge.
  - s_ready=0 on that beat.
- Idle outputs (IDLE/GAP, and at reset): dp=dn={DATA_WIDTH{IDLE_LEVEL}}, tx_en=0, frame_active=0.
- s_valid low on the final beat of a non-last word:
  - Go to IDLE. Outputs idle, but frame_active stays high (frame open).
  - The next accepted word continues the frame.
- s_data/s_last are ignored when s_ready=0. No combinational path from s_valid to s_ready.
- Reset (rst_n=0 at a clk edge): state=IDLE, counters=0, all outputs at idle values after that edge.
  - s_ready=1 in the first cycle after reset deasserts.
  - A word in flight is dropped with no partial completion.

Optional Feature:
DDR_TX_SEQ_PARITY_EN
- Defined: after the final beat of each last word, emit one extra PARITY beat with tx_en=1 and frame_active=1.
  - dp = XOR of all dp beats in the frame; dn = XOR of all dn beats (per lane bit).
  - Accumulators clear at frame start and on reset.
  - GAP follows the parity beat.
  - s_ready=0 during the parity beat.
- Undefined: no PARITY state or accumulators; the frame ends on the last data beat.

Test Plan:
- WORD_WIDTH=8, D=1, single word 0xB4 with s_last=1 -> beats (dp,dn) = (1,0),(1,1),(0,1),(0,0) on 4 consecutive clocks starting 1 clk after accept; tx_en high for exactly those 4; then 2 GAP clocks with s_ready=0; s_ready=1 on the 3rd clock.
- Frame 0xFF, 0x00 (last on 2nd), s_valid held high -> 8 contiguous beats (1,1)x4 then (0,0)x4; frame_active high for 8 clocks with no gap between words.
- s_valid dropped for 3 clocks between 0xA5 and 0x5A (last) -> tx_en low 3 clocks while frame_active stays high; beats resume with (0,1),(0,1),(1,0),(1,0).
- rst_n pulsed low during beat 2 of 0xB4 -> outputs idle (dp=dn=IDLE_LEVEL, tx_en=0) after that edge; s_ready=1 in the first cycle after deassert; next word transmits cleanly from beat 0.
- GAP_CYCLES=0, two single-word frames back-to-back -> at most 1 IDLE clock between frames, s_ready never high during SHIFT of a last word.
- With DDR_TX_SEQ_PARITY_EN, frame 0xB4 -> 5th beat (0,0) with tx_en=1; frame 0xB0 -> parity beat (0,1).
